// File: rtl/npu_mem_pkg.sv
// ============================================================================
// Module   : npu_mem_pkg
// Purpose  : Shared defaults, derived count widths and the write-FSM state
//            encoding for the compute-cluster memory load path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package npu_mem_pkg;

    localparam int BUS_SIZE_DEFAULT       = 32;
    localparam int WR_DAT_CYC_NUM_DEFAULT = 4;
    localparam int SRAM_NUM_DEFAULT       = 16;

    localparam int DAT_CNT_W_DEFAULT    = $clog2(WR_DAT_CYC_NUM_DEFAULT);
    localparam int CHUNK_W_DEFAULT      = $clog2(SRAM_NUM_DEFAULT);
    localparam int NUM_CHUNKS_W_DEFAULT = CHUNK_W_DEFAULT + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } wr_state_t;

endpackage

`default_nettype wire

// File: rtl/sparse_beat_compactor.sv
// ============================================================================
// Module   : sparse_beat_compactor
// Purpose  : Combinational sparsemap + prefix-popcount lane compaction of one
//            dense beat. Macro SPARSE_ENCODE_EN selects compaction; when it is
//            undefined the beat bypasses with an all-ones sparsemap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sparse_beat_compactor
    import npu_mem_pkg::*;
#(
    parameter int BUS_SIZE = BUS_SIZE_DEFAULT
) (
    input  logic [BUS_SIZE*8-1:0] dense_dat_i,
    output logic [BUS_SIZE-1:0]   sparsemap_o,
    output logic [BUS_SIZE*8-1:0] packed_o
);

`ifdef SPARSE_ENCODE_EN
    // Each nonzero byte lands in the lane equal to the count of nonzero bytes below it.
    always_comb begin
        int unsigned w_lane;
        sparsemap_o = '0;
        packed_o    = '0;
        w_lane      = 0;
        for (int k = 0; k < BUS_SIZE; k++) begin
            if (dense_dat_i[8*k +: 8] != 8'h00) begin
                sparsemap_o[k]          = 1'b1;
                packed_o[8*w_lane +: 8] = dense_dat_i[8*k +: 8];
                w_lane                  = w_lane + 1;
            end
        end
    end
`else
    assign sparsemap_o = '1;
    assign packed_o    = dense_dat_i;
`endif

endmodule

`default_nettype wire

// File: rtl/sparse_chunk_writer.sv
// ============================================================================
// Module   : sparse_chunk_writer
// Purpose  : Encodes dense beats and drives the SRAM write port for a run of
//            consecutive chunks. Encoding controlled by macro SPARSE_ENCODE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sparse_chunk_writer
    import npu_mem_pkg::*;
#(
    parameter int BUS_SIZE       = BUS_SIZE_DEFAULT,
    parameter int WR_DAT_CYC_NUM = WR_DAT_CYC_NUM_DEFAULT,
    parameter int SRAM_NUM       = SRAM_NUM_DEFAULT
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              start_i,
    input  logic [$clog2(SRAM_NUM)-1:0]       base_chunk_i,
    input  logic [$clog2(SRAM_NUM):0]         num_chunks_i,
    input  logic [BUS_SIZE*8-1:0]             dense_dat_i,
    input  logic                              dense_valid_i,
    output logic                              dense_ready_o,
    output logic [BUS_SIZE-1:0]               wr_sparsemap_o,
    output logic [BUS_SIZE*8-1:0]             wr_nonzero_data_o,
    output logic                              wr_valid_o,
    output logic [$clog2(WR_DAT_CYC_NUM)-1:0] wr_dat_count_o,
    output logic [$clog2(SRAM_NUM)-1:0]       wr_chunk_count_o,
    output logic                              busy_o,
    output logic                              done_o
);

    localparam int DCW = $clog2(WR_DAT_CYC_NUM);
    localparam int CW  = $clog2(SRAM_NUM);
    localparam logic [DCW-1:0] LAST_BEAT  = DCW'(WR_DAT_CYC_NUM - 1);
    localparam logic [CW-1:0]  LAST_CHUNK = CW'(SRAM_NUM - 1);

    wr_state_t             r_state;
    logic [CW-1:0]         r_chunk;
    logic [CW:0]           r_remaining;
    logic [DCW-1:0]        r_beat;
    logic                  r_ready;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_wr_valid;
    logic [BUS_SIZE-1:0]   r_map;
    logic [BUS_SIZE*8-1:0] r_data;
    logic [DCW-1:0]        r_dat_count;
    logic [CW-1:0]         r_chunk_count;

    logic [BUS_SIZE-1:0]   w_map;
    logic [BUS_SIZE*8-1:0] w_packed;
    logic                  w_accept;

    sparse_beat_compactor #(
        .BUS_SIZE (BUS_SIZE)
    ) u_compactor (
        .dense_dat_i (dense_dat_i),
        .sparsemap_o (w_map),
        .packed_o    (w_packed)
    );

    assign w_accept = dense_valid_i && r_ready;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state       <= ST_IDLE;
            r_chunk       <= '0;
            r_remaining   <= '0;
            r_beat        <= '0;
            r_ready       <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_wr_valid    <= 1'b0;
            r_map         <= '0;
            r_data        <= '0;
            r_dat_count   <= '0;
            r_chunk_count <= '0;
        end else begin
            r_wr_valid <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_chunk     <= base_chunk_i;
                        r_remaining <= num_chunks_i;
                        r_beat      <= '0;
                        r_busy      <= 1'b1;
                        if (num_chunks_i == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                            r_ready <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_accept) begin
                        r_wr_valid    <= 1'b1;
                        r_map         <= w_map;
                        r_data        <= w_packed;
                        r_dat_count   <= r_beat;
                        r_chunk_count <= r_chunk;
                        if (r_beat == LAST_BEAT) begin
                            r_beat      <= '0;
                            r_chunk     <= (r_chunk == LAST_CHUNK) ? '0 : r_chunk + CW'(1);
                            r_remaining <= r_remaining - (CW+1)'(1);
                            // Final beat of the run: completion rides with this write.
                            if (r_remaining == (CW+1)'(1)) begin
                                r_state <= ST_DONE;
                                r_ready <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_beat <= r_beat + DCW'(1);
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign dense_ready_o     = r_ready;
    assign busy_o            = r_busy;
    assign done_o            = r_done;
    assign wr_valid_o        = r_wr_valid;
    assign wr_sparsemap_o    = r_map;
    assign wr_nonzero_data_o = r_data;
    assign wr_dat_count_o    = r_dat_count;
    assign wr_chunk_count_o  = r_chunk_count;

endmodule

`default_nettype wire

// File: tb/tb_sparse_chunk_writer.sv
// ============================================================================
// Module   : tb_sparse_chunk_writer
// Purpose  : Scoreboard bench for sparse_chunk_writer; expected values follow
//            the SPARSE_ENCODE_EN setting of the build.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sparse_chunk_writer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [3:0]   base_chunk;
    logic [4:0]   num_chunks;
    logic [255:0] dense_dat;
    logic         dense_valid;
    logic         dense_ready;
    logic [31:0]  wr_map;
    logic [255:0] wr_data;
    logic         wr_valid;
    logic [1:0]   wr_dat_count;
    logic [3:0]   wr_chunk_count;
    logic         busy;
    logic         done;

    typedef struct {
        logic [31:0]  map;
        logic [255:0] data;
        logic [1:0]   dc;
        logic [3:0]   ch;
        logic         done;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    localparam logic [31:0]  ONES   = 32'hFFFF_FFFF;
    localparam logic [255:0] D_11   = {32{8'h11}};
    localparam logic [255:0] D_SP   = 256'h0700_0500;
    localparam logic [255:0] D_MIX  = {8'hCD, 224'h0, 8'hAB, 16'h0};
    localparam logic [255:0] D_ZERO = 256'h0;
`ifdef SPARSE_ENCODE_EN
    localparam logic [31:0]  E_SP_MAP   = 32'h0000_000A;
    localparam logic [255:0] E_SP_DAT   = 256'h0705;
    localparam logic [31:0]  E_MIX_MAP  = 32'h8000_0004;
    localparam logic [255:0] E_MIX_DAT  = 256'hCDAB;
    localparam logic [31:0]  E_ZERO_MAP = 32'h0;
`else
    localparam logic [31:0]  E_SP_MAP   = ONES;
    localparam logic [255:0] E_SP_DAT   = D_SP;
    localparam logic [31:0]  E_MIX_MAP  = ONES;
    localparam logic [255:0] E_MIX_DAT  = D_MIX;
    localparam logic [31:0]  E_ZERO_MAP = ONES;
`endif

    sparse_chunk_writer u_dut (
        .clk_i             (clk),
        .rst_i             (rst_n),
        .start_i           (start),
        .base_chunk_i      (base_chunk),
        .num_chunks_i      (num_chunks),
        .dense_dat_i       (dense_dat),
        .dense_valid_i     (dense_valid),
        .dense_ready_o     (dense_ready),
        .wr_sparsemap_o    (wr_map),
        .wr_nonzero_data_o (wr_data),
        .wr_valid_o        (wr_valid),
        .wr_dat_count_o    (wr_dat_count),
        .wr_chunk_count_o  (wr_chunk_count),
        .busy_o            (busy),
        .done_o            (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(logic [31:0] m, logic [255:0] d, int dc, int ch, bit dn);
        exp_t e;
        e.map  = m;
        e.data = d;
        e.dc   = 2'(dc);
        e.ch   = 4'(ch);
        e.done = dn;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int b, input int n);
        base_chunk = 4'(b);
        num_chunks = 5'(n);
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    // Presents one beat, waits (bounded) for ready, queues its expected write.
    task automatic send(input logic [255:0] d, input exp_t e);
        int n = 0;
        dense_valid = 1'b1;
        dense_dat   = d;
        while (!dense_ready) begin
            if (n > 50) begin
                n_checks++;
                n_fail++;
                $display("FAIL ready_timeout: ready stayed %0b expected 1", dense_ready);
                dense_valid = 1'b0;
                return;
            end
            tick();
            n++;
        end
        q.push_back(e);
        tick();
    endtask

    // Monitor: every write the DUT presents is popped and compared.
    always @(negedge clk) begin
        if (rst_n && wr_valid) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: dat_count %0d chunk %0d with empty queue",
                         wr_dat_count, wr_chunk_count);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("wr_sparsemap", wr_map, e.map);
                chk("wr_data", wr_data, e.data);
                chk("wr_dat_count", wr_dat_count, e.dc);
                chk("wr_chunk_count", wr_chunk_count, e.ch);
                chk("done_on_write", done, e.done);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
        $fatal(1);
    end

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        base_chunk  = '0;
        num_chunks  = '0;
        dense_dat   = '0;
        dense_valid = 1'b0;
        repeat (3) tick();
        chk("reset_outputs", {wr_valid, busy, done, dense_ready, wr_dat_count, wr_chunk_count}, 0);
        chk("reset_map", wr_map, 0);
        chk("reset_data", wr_data, 0);
        rst_n = 1'b1;
        tick();

        // Dense run: base 2, one chunk of 0x11 beats.
        do_start(2, 1);
        chk("busy_after_start", {busy, dense_ready}, 2'b11);
        for (int i = 0; i < 4; i++) send(D_11, mk(ONES, D_11, i, 2, i == 3));
        dense_valid = 1'b0;
        chk("busy_in_done", busy, 1);
        tick();
        chk("busy_drop", {busy, dense_ready, done}, 0);

        // Encoding patterns.
        do_start(0, 1);
        send(D_SP,   mk(E_SP_MAP, E_SP_DAT, 0, 0, 0));
        send(D_MIX,  mk(E_MIX_MAP, E_MIX_DAT, 1, 0, 0));
        send(D_ZERO, mk(E_ZERO_MAP, 256'h0, 2, 0, 0));
        send(D_11,   mk(ONES, D_11, 3, 0, 1));
        dense_valid = 1'b0;
        repeat (2) tick();

        // Chunk counter wrap from slot 15 to slot 0.
        do_start(15, 2);
        for (int i = 0; i < 8; i++) begin
            logic [7:0]   b;
            logic [255:0] d;
            b = 8'(8'h20 + i);
            d = {32{b}};
            send(d, mk(ONES, d, i % 4, (i < 4) ? 15 : 0, i == 7));
        end
        dense_valid = 1'b0;
        repeat (2) tick();

        // Valid gap with an ignored mid-run start.
        do_start(3, 1);
        send(D_11, mk(ONES, D_11, 0, 3, 0));
        dense_valid = 1'b0;
        base_chunk  = 4'd9;
        num_chunks  = 5'd0;
        start       = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("gap_no_write", wr_valid, 0);
        chk("gap_hold_count", wr_dat_count, 0);
        chk("gap_busy", busy, 1);
        send(D_MIX, mk(E_MIX_MAP, E_MIX_DAT, 1, 3, 0));
        send(D_SP,  mk(E_SP_MAP, E_SP_DAT, 2, 3, 0));
        send(D_11,  mk(ONES, D_11, 3, 3, 1));
        dense_valid = 1'b0;
        repeat (2) tick();

        // Empty run: done next cycle, no write.
        do_start(7, 0);
        @(negedge clk);
        chk("num0_done", {done, busy, wr_valid, dense_ready}, 4'b1100);
        @(negedge clk);
        chk("num0_after", {done, busy}, 0);
        tick();

        // Asynchronous reset mid-chunk, then restart at slot 5.
        do_start(9, 1);
        send(D_11, mk(ONES, D_11, 0, 9, 0));
        send(D_SP, mk(E_SP_MAP, E_SP_DAT, 1, 9, 0));
        dense_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_ctl", {wr_valid, busy, done, dense_ready, wr_dat_count, wr_chunk_count}, 0);
        chk("async_reset_data", {wr_map, wr_data}, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_after_reset", {busy, dense_ready}, 0);
        do_start(5, 1);
        send(D_MIX, mk(E_MIX_MAP, E_MIX_DAT, 0, 5, 0));
        send(D_11,  mk(ONES, D_11, 1, 5, 0));
        send(D_ZERO, mk(E_ZERO_MAP, 256'h0, 2, 5, 0));
        send(D_11,  mk(ONES, D_11, 3, 5, 1));
        dense_valid = 1'b0;
        repeat (3) tick();

        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sparse_chunk_writer.md
# sparse_chunk_writer

Sparse encoder and write-port driver that feeds the IFM and filter SRAM write ports of the compute-cluster memory wrapper. It accepts dense byte beats over a valid/ready stream and compresses each beat into a sparsemap (one bit per byte, 1 = nonzero) plus nonzero bytes packed toward lane 0. It drives the SRAM write interface (`wr_valid`, data-cycle count, chunk count) for a programmed run of consecutive chunks. One instance is placed per SRAM (IFM, filter) on the load path from the DMA.

## Interface
- `BUS_SIZE`, default 32: bytes per beat; sparsemap width.
- `WR_DAT_CYC_NUM`, default 4: beats per chunk.
- `SRAM_NUM`, default 16: chunk slots in the target SRAM.

Ports:
- `clk_i` in 1: single clock.
- `rst_i` in 1: asynchronous, active-low reset.
- `start_i` in 1: one-cycle pulse; begins a run. Sampled only in IDLE.
- `base_chunk_i` in clog2(SRAM_NUM): first chunk slot of the run.
- `num_chunks_i` in clog2(SRAM_NUM)+1: number of chunks in the run (0..SRAM_NUM).
- `dense_dat_i` in BUS_SIZE*8: dense beat; byte k is at bits [8k+7:8k].
- `dense_valid_i` in 1: beat valid.
- `dense_ready_o` out 1: beat accepted when valid and ready are both high.
- `wr_sparsemap_o` out BUS_SIZE: bit k = (byte k != 0).
- `wr_nonzero_data_o` out BUS_SIZE*8: nonzero bytes compacted in original order from lane 0; unused lanes are 0.
- `wr_valid_o` out 1: write strobe to the SRAM.
- `wr_dat_count_o` out clog2(WR_DAT_CYC_NUM): beat index within the chunk.
- `wr_chunk_count_o` out clog2(SRAM_NUM): target chunk slot.
- `busy_o` out 1: high in RUN and DONE.
- `done_o` out 1: one-cycle pulse on the final write of a run.

## Operation
- States:
  - IDLE: `start_i` → RUN. If `num_chunks_i`=0, go to DONE instead.
  - RUN: after the last beat of the last chunk is accepted → DONE.
  - DONE: one cycle, then → IDLE.
- On start, latch `base_chunk_i` into the chunk counter and `num_chunks_i` into the remaining-chunks counter. Clear the beat counter.
- `dense_ready_o` = (state==RUN). There is no backpressure from the SRAM.
- Per accepted beat:
  - Register the encoded sparsemap and packed data, beat counter and chunk counter into the output stage, with `wr_valid_o`=1.
  - Increment the beat counter.
  - When the beat counter reaches WR_DAT_CYC_NUM-1, it wraps to 0. The chunk counter then increments modulo SRAM_NUM (wrap-around is legal) and remaining-chunks decrements.
- Cycles with no accepted beat: `wr_valid_o`=0. Counts and data outputs hold their last values.
- `start_i` in RUN or DONE is ignored.
- Packing: the output lane of byte k is popcount(sparsemap[k-1:0]). An all-zero beat gives sparsemap 0 and data 0. An all-nonzero beat passes through unchanged.

## Timing
- Reset values: all outputs 0; state IDLE; all counters 0.
- `start_i` at cycle t → `busy_o`/`dense_ready_o` high at t+1.
- Beat accepted at cycle t → `wr_*` outputs presented at t+1. Latency is 1, with one registered stage.
- `done_o` is asserted in the same cycle as the final `wr_valid_o`; `busy_o` drops the next cycle. With `num_chunks_i`=0, `done_o` is high at t+1 with no write.
- Reset asserted mid-run: immediate return to reset values. The partial chunk is abandoned; no completion is signalled.

## Configuration
- `SPARSE_ENCODE_EN`
  - Defined: the compaction described above.
  - Undefined: bypass. `wr_sparsemap_o` is all ones and `wr_nonzero_data_o` = `dense_dat_i`. This is used for dense-mode bring-up. Timing, counters and FSM are identical in both modes.

## Structure
- The shared package `npu_mem_pkg` holds:
  - the BUS_SIZE / WR_DAT_CYC_NUM / SRAM_NUM defaults and the derived count widths;
  - the FSM state enum (IDLE, RUN, DONE).
- Sub-module `sparse_beat_compactor`: combinational. It produces the sparsemap and prefix-popcount lane compaction for one beat, and is instantiated once.

## Test plan
- Reset, then start with base=2, num=1, and 4 all-0x11 beats with continuous valid. Required: 4 writes on consecutive cycles, dat_count 0,1,2,3, chunk_count 2, sparsemap 0xFFFFFFFF, data unchanged, `done_o` on the 4th write.
- Beat where byte1=0x05, byte3=0x07 and all others 0. Required: sparsemap 0x0000000A, data byte0=0x05, byte1=0x07, rest 0. With `SPARSE_ENCODE_EN` undefined: sparsemap 0xFFFFFFFF and data equal to the input.
- base=15, num=2, 8 beats. Required: chunk_count 15 for beats 0–3, then 0 for beats 4–7 (wrap).
- Valid gaps: valid toggles 1,0,1 → `wr_valid_o` 1,0,1 with dat_count 0,(hold 0),1. A second `start_i` mid-run is ignored.
- num=0 → `done_o` one cycle after start, with no `wr_valid_o`.
- `rst_i` low after 2 beats of a 4-beat chunk. Required: outputs 0 asynchronously and state IDLE. A restart with base=5 then writes chunk 5 from dat_count 0.
